// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx byte transmitter between N_REQ requesters.
// Each accepted byte produces a one-cycle tx_trig; a full-frame timer spaces consecutive triggers.
module uart_tx_sched #(
  parameter int N_REQ    = 4,
  parameter int BAUD_DIV = 434,
  parameter int GUARD    = 4
) (
  input  logic               sclk,
  input  logic               s_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_trig,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [1:0]         grant_id
);

  localparam int          FRAME_CYC  = 10 * BAUD_DIV + GUARD;
  localparam logic [15:0] FRAME_LOAD = 16'(FRAME_CYC - 1);
  localparam logic [2:0]  N_REQ_L    = 3'(N_REQ);

  if (FRAME_CYC > 65535 || FRAME_CYC < 1 || N_REQ < 2 || N_REQ > 4) begin : g_param_check
    $error("uart_tx_sched: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;

  // Requester vectors widened to four lanes so indexing is uniform for any N_REQ.
  logic [3:0]  valid_pad;
  logic [31:0] data_pad;
  logic [3:0]  ready_pad;

  assign valid_pad = 4'(req_valid);
  assign data_pad  = 32'(req_data);

  logic       sel_found;
  logic [1:0] sel_idx;
  logic [2:0] cand;

  // Cyclic search starting at the round-robin pointer; first set valid bit wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + 3'(k);
      if (cand >= N_REQ_L) cand = cand - N_REQ_L;
      if (!sel_found && valid_pad[cand[1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    busy_d    = busy_q;
    ready_pad = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          ready_pad[sel_idx] = 1'b1;
          data_d  = data_pad[{sel_idx, 3'b000} +: 8];
          grant_d = sel_idx;
          ptr_d   = ({1'b0, sel_idx} == N_REQ_L - 3'd1) ? 2'd0 : sel_idx + 2'd1;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = FRAME_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 16'd0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = ready_pad[N_REQ-1:0];
  assign tx_trig   = (state_q == LOAD);
  assign tx_data   = data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: default 4-requester build plus a 2-requester short-frame build.
module tb_uart_tx_sched;

  localparam int FRAME0 = 10 * 434 + 4;  // 4344
  localparam int FRAME1 = 10 * 57 + 2;   // 572

  logic sclk    = 1'b0;
  logic s_rst_n = 1'b1;
  always #5 sclk = ~sclk;

  logic [3:0]  rv0;
  logic [31:0] rd0;
  logic [3:0]  rr0;
  logic        trig0;
  logic [7:0]  txd0;
  logic        busy0;
  logic [1:0]  gid0;

  logic [1:0]  rv1;
  logic [15:0] rd1;
  logic [1:0]  rr1;
  logic        trig1;
  logic [7:0]  txd1;
  logic        busy1;
  logic [1:0]  gid1;

  uart_tx_sched u0 (
    .sclk(sclk), .s_rst_n(s_rst_n), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .tx_trig(trig0), .tx_data(txd0), .busy(busy0), .grant_id(gid0)
  );

  uart_tx_sched #(.N_REQ(2), .BAUD_DIV(57), .GUARD(2)) u1 (
    .sclk(sclk), .s_rst_n(s_rst_n), .req_valid(rv1), .req_data(rd1), .req_ready(rr1),
    .tx_trig(trig1), .tx_data(txd1), .busy(busy1), .grant_id(gid1)
  );

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int last_trig0 = 0;
  int last_trig1 = 0;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic [1:0]  gid;
    logic [7:0]  dat;
    bit          sp;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no req_ready within cycle budget", name);
  endtask

  // Present a request, wait for its accept, then check the trigger cycle that follows.
  task automatic frame0(input logic [3:0] v, input logic [31:0] d, input logic [3:0] exp_rdy,
                        input logic [1:0] exp_gid, input logic [7:0] exp_dat, input bit chk_sp,
                        input string tag);
    int waited;
    waited = 0;
    rv0 = v;
    rd0 = d;
    #1;
    while (rr0 == 4'b0000 && waited < 2 * FRAME0) begin
      @(negedge sclk);
      waited++;
    end
    if (rr0 == 4'b0000) begin
      timeout_fail(tag);
      return;
    end
    check($sformatf("%s ready", tag), 32'(rr0), 32'(exp_rdy));
    check($sformatf("%s busy@accept", tag), 32'(busy0), 32'd0);
    @(negedge sclk);
    check($sformatf("%s trig", tag), 32'(trig0), 32'd1);
    check($sformatf("%s data", tag), 32'(txd0), 32'(exp_dat));
    check($sformatf("%s grant", tag), 32'(gid0), 32'(exp_gid));
    check($sformatf("%s busy@trig", tag), 32'(busy0), 32'd1);
    check($sformatf("%s ready@trig", tag), 32'(rr0), 32'd0);
    if (chk_sp) check($sformatf("%s spacing", tag), 32'(cyc - last_trig0), 32'(FRAME0 + 2));
    last_trig0 = cyc;
  endtask

  task automatic frame1(input logic [1:0] v, input logic [15:0] d, input logic [1:0] exp_rdy,
                        input logic [1:0] exp_gid, input logic [7:0] exp_dat, input bit chk_sp,
                        input string tag);
    int waited;
    waited = 0;
    rv1 = v;
    rd1 = d;
    #1;
    while (rr1 == 2'b00 && waited < 2 * FRAME1) begin
      @(negedge sclk);
      waited++;
    end
    if (rr1 == 2'b00) begin
      timeout_fail(tag);
      return;
    end
    check($sformatf("%s ready", tag), 32'(rr1), 32'(exp_rdy));
    @(negedge sclk);
    check($sformatf("%s trig", tag), 32'(trig1), 32'd1);
    check($sformatf("%s data", tag), 32'(txd1), 32'(exp_dat));
    check($sformatf("%s grant", tag), 32'(gid1), 32'(exp_gid));
    if (chk_sp) check($sformatf("%s spacing", tag), 32'(cyc - last_trig1), 32'(FRAME1 + 2));
    last_trig1 = cyc;
  endtask

  task automatic pulse_reset();
    @(negedge sclk);
    s_rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    @(negedge sclk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [31:0] d4;
    d4 = 32'h4332_2110;
    tbl[0]  = '{4'b1111, d4, 4'b0001, 2'd0, 8'h10, 1'b0};
    tbl[1]  = '{4'b1111, d4, 4'b0010, 2'd1, 8'h21, 1'b1};
    tbl[2]  = '{4'b1111, d4, 4'b0100, 2'd2, 8'h32, 1'b1};
    tbl[3]  = '{4'b1111, d4, 4'b1000, 2'd3, 8'h43, 1'b1};
    tbl[4]  = '{4'b1111, d4, 4'b0001, 2'd0, 8'h10, 1'b1};
    tbl[5]  = '{4'b1000, d4, 4'b1000, 2'd3, 8'h43, 1'b1};
    tbl[6]  = '{4'b1001, d4, 4'b0001, 2'd0, 8'h10, 1'b1};
    tbl[7]  = '{4'b0001, d4, 4'b0001, 2'd0, 8'h10, 1'b1};
    tbl[8]  = '{4'b0011, d4, 4'b0010, 2'd1, 8'h21, 1'b1};
    tbl[9]  = '{4'b0001, d4, 4'b0001, 2'd0, 8'h10, 1'b1};
    tbl[10] = '{4'b0100, d4, 4'b0100, 2'd2, 8'h32, 1'b1};

    rv0 = '0; rd0 = '0; rv1 = '0; rd1 = '0;
    #2 s_rst_n = 1'b0;
    #1;
    check("rst trig", 32'(trig0), 32'd0);
    check("rst data", 32'(txd0), 32'h00);
    check("rst busy", 32'(busy0), 32'd0);
    check("rst grant", 32'(gid0), 32'd0);
    check("rst ready", 32'(rr0), 32'd0);
    check("rst busy u1", 32'(busy1), 32'd0);
    repeat (3) @(negedge sclk);
    s_rst_n = 1'b1;
    @(negedge sclk);

    // Single byte: immediate accept, trig next cycle, busy through the whole frame.
    frame0(4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 8'hA5, 1'b0, "t1");
    rv0 = '0;
    bad = 0;
    repeat (FRAME0) begin
      @(negedge sclk);
      if (busy0 !== 1'b1 || rr0 !== 4'b0000) bad++;
    end
    check("t1 busy held", 32'(bad), 32'd0);
    @(negedge sclk);
    check("t1 busy fall", 32'(busy0), 32'd0);
    check("t1 data hold", 32'(txd0), 32'hA5);

    pulse_reset();
    for (int i = 0; i < 11; i++)
      frame0(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].gid, tbl[i].dat, tbl[i].sp,
             $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a frame.
    repeat (2000) @(negedge sclk);
    #2 s_rst_n = 1'b0;
    #1;
    check("t5 busy", 32'(busy0), 32'd0);
    check("t5 trig", 32'(trig0), 32'd0);
    check("t5 data", 32'(txd0), 32'h00);
    check("t5 grant", 32'(gid0), 32'd0);
    @(negedge sclk);
    s_rst_n = 1'b1;
    frame0(4'b1111, d4, 4'b0001, 2'd0, 8'h10, 1'b0, "t5 post");
    rv0 = '0;

    // Two-requester build with a short frame.
    frame1(2'b11, 16'hB2A1, 2'b01, 2'd0, 8'hA1, 1'b0, "n2 a");
    frame1(2'b11, 16'hB2A1, 2'b10, 2'd1, 8'hB2, 1'b1, "n2 b");
    frame1(2'b11, 16'hB2A1, 2'b01, 2'd0, 8'hA1, 1'b1, "n2 c");
    rv1 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx byte transmitter between up to four requesters.
- Accepts bytes via per-requester valid/ready handshakes and issues a one-cycle tx_trig with tx_data.
- Enforces a full-frame spacing timer between triggers, including start, 8 data and stop bits plus guard time. The transmitter has no busy output and drops triggers while it is active, so this spacing is required.
- Sits between the application/command logic and uart_tx. It shares sclk/s_rst_n with uart_tx.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..4.
- BAUD_DIV, 434, sclk cycles per UART bit; must equal the uart_tx baud divisor (50 MHz, 115200).
- GUARD, 4, extra idle cycles added after each frame.

Ports:
- sclk, input, 1, system clock.
- s_rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, N_REQ, per-requester byte-valid.
- req_data, input, 8*N_REQ, byte for requester i on bits [8i+7:8i].
- req_ready, output, N_REQ, one-hot accept strobe; byte i is transferred when req_valid[i] and req_ready[i] are both high.
- tx_trig, output, 1, one-cycle start pulse to uart_tx.
- tx_data, output, 8, byte to uart_tx; stable from the trig cycle until the next trig.
- busy, output, 1, high from the accept cycle until the frame timer expires.
- grant_id, output, 2, index of the most recently accepted requester.

Behaviour:
Clock and reset:
- One clock, sclk. Reset is asynchronous, active-low (s_rst_n); all flops clear immediately on its assertion.
- Reset values: tx_trig=0, tx_data=8'h00, busy=0, grant_id=0, req_ready=0, state=IDLE, frame counter=0, RR pointer=0 (requester 0 has first priority).

FSM states:
- IDLE
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise select the first set req_valid bit, searching cyclically from the RR pointer (pointer, pointer+1, ... wrap modulo N_REQ).
  - req_ready is combinational (Mealy): asserted one-hot for the selected requester in this cycle only; all other bits are 0.
  - On the clock edge:
    - latch the selected byte into tx_data;
    - grant_id <= selected index;
    - RR pointer <= (selected+1) mod N_REQ;
    - busy <= 1;
    - go to LOAD.
- LOAD (1 cycle)
  - tx_trig=1 and tx_data holds the latched byte.
  - Load the frame counter with FRAME_CYC-1, where FRAME_CYC = 10*BAUD_DIV + GUARD (4344 by default).
  - Go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - When the counter reaches 0: busy <= 0 and go to IDLE.
  - req_ready stays 0 throughout WAIT.

Latency and spacing:
- Accept-to-trig latency is 1 cycle.
- Consecutive tx_trig pulses are spaced exactly FRAME_CYC+2 cycles apart under continuous demand: 1 LOAD cycle, FRAME_CYC WAIT cycles, 1 IDLE/accept cycle.

Counter width and parameter checks:
- Frame counter is 16 bits.
- The elaboration-time check requires FRAME_CYC <= 65535 and 2 <= N_REQ <= 4.

Handshake rules:
- A requester holds req_valid and req_data stable until it sees ready.
- req_valid dropping before ready is tolerated: that requester is simply not selected. There is no partial transfer.
- req_valid of unselected requesters is ignored outside IDLE.
- Only one acceptance is possible per frame.

Boundary conditions:
- All requesters valid: grants rotate strictly, e.g. 0,1,2,3,0,...
- Single requester continuously valid: it is granted every frame; no starvation of the others once they assert.
- A valid bit arriving during WAIT is serviced at the next IDLE in RR order.
- Reset mid-frame: outputs return to reset values and the pointer returns to 0. uart_tx is reset by the same signal, so no frame resumes.
- Upper req_data bits beyond N_REQ*8 do not exist. grant_id values >= N_REQ never occur.

Test Plan:
1. Reset, then req_valid=4'b0001, req_data[7:0]=8'hA5 held.
   - req_ready[0] pulses for 1 cycle, tx_trig follows 1 cycle later with tx_data=8'hA5, busy=1.
   - busy falls 4344 cycles after the trig cycle.
   - With uart_tx connected, rs232_tx shows start bit, then 1,0,1,0,0,1,0,1 (LSB first), then idle high.
2. All four valid with bytes 8'h10,8'h21,8'h32,8'h43 held.
   - grant_id sequence is 0,1,2,3,0; tx_data sequence is 10,21,32,43,10.
   - Trigs are spaced exactly 4346 cycles apart.
3. req_valid=4'b0100 asserted during WAIT of a requester-0 frame.
   - No req_ready until IDLE; then req_ready=4'b0100 and grant_id=2.
4. Pointer wrap: after a grant to requester 3, assert req_valid=4'b1001.
   - Requester 0 is granted next.
5. Assert s_rst_n=0 mid-WAIT, ~2000 cycles in.
   - Immediately busy=0, tx_trig=0, tx_data=8'h00, grant_id=0.
   - After release with req_valid=4'b1111, requester 0 is granted first.
6. N_REQ=2, BAUD_DIV=57, GUARD=2 (sim build).
   - FRAME_CYC is 572; trig spacing is 574; only req_ready[1:0] are toggled.
